// File: rtl/data_mem_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers each accepted request with a
// one-cycle ack a fixed LATENCY cycles later. Requests arriving while a
// transaction is outstanding are dropped, never queued.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic      clk,
  input logic      rst_n,
  data_mem_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;

  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;

  logic [31:0]      mem [DEPTH];

  logic             resp;
  logic             bad;
  logic [IDX_W-1:0] idx;

  logic             ack_nxt, err_nxt, mem_wr;
  logic [31:0]      rdata_nxt;
  logic             ack_q, err_q;
  logic [31:0]      rdata_q;

  // The response edge is the one that sees the counter already at zero in WAIT.
  assign resp = (state == WAIT) && (cnt == 4'd0);
  // Misaligned or beyond-the-end addresses are answered with err and never touch memory.
  assign bad  = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
  assign idx  = lat_addr[IDX_W+1:2];

  // State and latency counter; reset aborts any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Accept in IDLE, count down in WAIT, return to IDLE on the response edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on acceptance so later bus changes cannot affect it.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      lat_we    <= bus.we;
      lat_addr  <= bus.addr;
      lat_wdata <= bus.wdata;
    end
  end

  // Response decode: ack/err only on the response edge, rdata held otherwise.
  always_comb begin
    ack_nxt   = resp;
    err_nxt   = 1'b0;
    rdata_nxt = rdata_q;
    mem_wr    = 1'b0;
    if (resp) begin
      err_nxt = bad;
      if (bad) begin
        if (!lat_we) rdata_nxt = 32'd0;
      end else if (lat_we) begin
        mem_wr = 1'b1;
      end else begin
        rdata_nxt = mem[idx];
      end
    end
  end

  // Registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q   <= ack_nxt;
      err_q   <= err_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  // Store commit; gated by the FSM so a store aborted by reset never lands.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[idx] <= lat_wdata;
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance (a) and a
// LATENCY=1 instance (b), random traffic against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_if bus_a ();
  data_mem_if bus_b ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] ref_mem [longint unsigned];
  logic [31:0] last_rd [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory is a plain word map; errors follow the address rules.
  function automatic void model(bit sel, bit w, logic [31:0] a, logic [31:0] d, int due);
    exp_t            e;
    longint unsigned key;
    logic            err;
    err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    key = (longint'(sel) << 32) | longint'(a >> 2);
    if (err) begin
      if (!w) last_rd[sel] = 32'd0;
    end else if (w) begin
      ref_mem[key] = d;
    end else begin
      last_rd[sel] = ref_mem.exists(key) ? ref_mem[key] : 32'hxxxx_xxxx;
    end
    e.err   = err;
    e.rdata = last_rd[sel];
    e.due   = due;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endfunction

  task automatic check_resp(bit sel, logic err, logic [31:0] rdata);
    exp_t e;
    if ((sel ? q_b.size() : q_a.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack[%0d]: ack with nothing outstanding (cycle %0d)", sel, cyc);
    end else begin
      e = sel ? q_b.pop_front() : q_a.pop_front();
      chk(sel ? "ack_time_b" : "ack_time_a", 32'(cyc), 32'(e.due));
      chk(sel ? "err_b" : "err_a", {31'd0, err}, {31'd0, e.err});
      chk(sel ? "rdata_b" : "rdata_a", rdata, e.rdata);
    end
  endtask

  // Monitors: every ack is matched against the oldest expected response.
  always @(negedge clk) if (bus_a.ack === 1'b1) check_resp(1'b0, bus_a.err, bus_a.rdata);
  always @(negedge clk) if (bus_b.ack === 1'b1) check_resp(1'b1, bus_b.err, bus_b.rdata);

  task automatic drive(bit sel, logic r, logic w, logic [31:0] a, logic [31:0] d);
    if (sel) begin
      bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
    end else begin
      bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
    end
  endtask

  function automatic logic get_busy(bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction

  // Issue one transaction at a negedge; junk is driven while it is outstanding.
  // Returns at the negedge inside the ack cycle, ready for a back-to-back request.
  task automatic xact(bit sel, bit w, logic [31:0] a, logic [31:0] d, bit hold);
    int lat;
    lat = sel ? 1 : 2;
    drive(sel, 1'b1, w, a, d);
    model(sel, w, a, d, cyc + 1 + lat);
    @(posedge clk);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_set", {31'd0, get_busy(sel)}, 32'd1);
      drive(sel, hold ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("busy_clr", {31'd0, get_busy(sel)}, 32'd0);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idle(int n);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)       return 32'($urandom_range(0, 15)) << 2;
    else if (r == 6) return 32'(DEPTH - 1) << 2;
    else if (r == 7) return (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'(DEPTH + $urandom_range(0, 1000)) << 2;
    else             return 32'h8000_0000 | $urandom;
  endfunction

  initial begin
    int acks;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    idle(0);

    // Reset applied before any clock edge clears the outputs immediately.
    rst_n = 1'b0;
    #2;
    chk("rst_rdata", bus_a.rdata, 32'd0);
    chk("rst_ack", {31'd0, bus_a.ack}, 32'd0);
    chk("rst_err", {31'd0, bus_a.err}, 32'd0);
    chk("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load.
    xact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    xact(1'b0, 1'b0, 32'h10, 32'd0, 1'b0);
    idle(1);

    // Prefill every index the random traffic may load from, on both instances.
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, 1'b1, 32'(i) << 2, $urandom, 1'b0);
      xact(1'b1, 1'b1, 32'(i) << 2, $urandom, 1'b0);
    end
    xact(1'b0, 1'b1, 32'(DEPTH - 1) << 2, $urandom, 1'b0);
    xact(1'b1, 1'b1, 32'(DEPTH - 1) << 2, $urandom, 1'b0);

    // Error responses: misaligned load, out-of-range store, then a clean load.
    xact(1'b0, 1'b0, 32'h12, 32'd0, 1'b0);
    xact(1'b0, 1'b1, 32'h400, 32'h5A5A_5A5A, 1'b0);
    xact(1'b0, 1'b0, 32'h0, 32'd0, 1'b0);

    // Back-to-back with req held high through WAIT.
    xact(1'b0, 1'b1, 32'h4, 32'h1, 1'b1);
    xact(1'b0, 1'b1, 32'h4, 32'h2, 1'b1);
    xact(1'b0, 1'b1, 32'h4, 32'h1, 1'b1);
    xact(1'b0, 1'b1, 32'h4, 32'h2, 1'b1);
    xact(1'b0, 1'b0, 32'h4, 32'd0, 1'b1);

    // Reset during the ack cycle of a load clears everything at once.
    xact(1'b0, 1'b0, 32'h10, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_ack", {31'd0, bus_a.ack}, 32'd0);
    chk("rst2_rdata", bus_a.rdata, 32'd0);
    chk("rst2_busy", {31'd0, bus_a.busy}, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store aborted by reset must not commit and must never ack.
    xact(1'b0, 1'b1, 32'h8, 32'h1234_5678, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA_5555);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 chk("abort_busy", {31'd0, bus_a.busy}, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_a.ack === 1'b1) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    xact(1'b0, 1'b0, 32'h8, 32'd0, 1'b0);

    // LATENCY=1 instance: load then back-to-back store/load.
    xact(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
    xact(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b1);
    xact(1'b1, 1'b0, 32'h20, 32'd0, 1'b1);
    xact(1'b1, 1'b0, 32'h13, 32'd0, 1'b0);

    // Random traffic on both instances with random gaps.
    for (int n = 0; n < 400; n++) begin
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(5);
    chk("pending_a", 32'(q_a.size()), 32'd0);
    chk("pending_b", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
